// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C master sequencer driving the SCL/SDA open-drain enables.
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack_out,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       busy,
    output logic       bus_active,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);
    typedef enum logic [2:0] {IDLE, START, BIT, STOP, RESP} state_t;

    state_t      state;
    logic [15:0] div;
    logic [1:0]  q;
    logic [3:0]  idx;
    logic [1:0]  op;
    logic [7:0]  data;
    logic        ack;
    logic [7:0]  sh;
    logic        nack_s;
    logic        hold;
    logic        tick;

`ifdef I2C_CLK_STRETCH_EN
    // a slave holding SCL low freezes the divider in the SCL-high quarter
    assign hold = ~scl_in && ((state == BIT && q == 2'd2) || ((state == START || state == STOP) && q == 2'd1));
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold = 1'b0;
`endif

    assign tick = (state == START || state == BIT || state == STOP) && !hold && div == 16'(CLK_DIV - 1);

    // SDA level for a bit slot: write data MSB first, release for the slave ACK, master ACK on read
    function automatic logic drive(input logic [1:0] o, input logic [7:0] d, input logic a, input logic [3:0] i);
        return (i == 4'd8) ? (o == 2'd2 && !a) : (o == 2'd1 && !d[3'd7 - i[2:0]]);
    endfunction

    // command sequencer: quarter-period divider, bus phases and registered line/response outputs
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state      <= IDLE;
            div        <= '0;
            q          <= '0;
            idx        <= '0;
            op         <= '0;
            data       <= '0;
            ack        <= 1'b0;
            sh         <= '0;
            nack_s     <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_nack   <= 1'b0;
            rsp_err    <= 1'b0;
            bus_active <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            div <= (state == IDLE || state == RESP || hold || tick) ? 16'd0 : div + 16'd1;
            if (tick) q <= q + 2'd1;
            case (state)
                IDLE: if (cmd_valid) begin
                    op        <= cmd_op;
                    data      <= cmd_data;
                    ack       <= cmd_ack_out;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    q         <= '0;
                    idx       <= '0;
                    rsp_err   <= 1'b0;
                    if (cmd_op == 2'd0) begin
                        state  <= START;
                        sda_oe <= 1'b0;
                    end else if (!bus_active) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (cmd_op == 2'd3) begin
                        state  <= STOP;
                        sda_oe <= 1'b1;
                        scl_oe <= 1'b1;
                    end else begin
                        state  <= BIT;
                        sda_oe <= drive(cmd_op, cmd_data, cmd_ack_out, 4'd0);
                    end
                end
                START: if (tick) begin
                    if (q == 2'd0) scl_oe <= 1'b0;
                    if (q == 2'd1) sda_oe <= 1'b1;
                    if (q == 2'd3) begin
                        scl_oe     <= 1'b1;
                        bus_active <= 1'b1;
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                    end
                end
                BIT: if (tick) begin
                    if (q == 2'd1) scl_oe <= 1'b0;
                    if (q == 2'd2) begin
                        if (idx == 4'd8) nack_s <= (op == 2'd2) ? ack : sda_in;
                        else sh <= {sh[6:0], sda_in};
                    end
                    if (q == 2'd3) begin
                        scl_oe <= 1'b1;
                        if (idx == 4'd8) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= sh;
                            rsp_nack  <= nack_s;
                        end else begin
                            idx    <= idx + 4'd1;
                            sda_oe <= drive(op, data, ack, idx + 4'd1);
                        end
                    end
                end
                STOP: if (tick) begin
                    if (q == 2'd0) scl_oe <= 1'b0;
                    if (q == 2'd2) sda_oe <= 1'b0;
                    if (q == 2'd3) begin
                        bus_active <= 1'b0;
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: table-driven scoreboard bench for i2c_master_ctrl with a simple slave model.
module tb_i2c_master_ctrl;
    localparam int DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam int LS = 165;
`else
    localparam int LS = 145;
`endif

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic       ack;
        logic [7:0] rd;
        logic       sack;
        logic       st;
        logic       poke;
        int         lat;
        logic       err;
        logic       bus;
        logic       chk;
        logic [7:0] edata;
        logic       enack;
        logic [8:0] eseen;
        logic       chk_or;
        logic [1:0] eor;
        logic       chk_tim;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ = 1'b1;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic cmd_ack_out = 1'b0;
    logic cmd_ready, rsp_valid, rsp_nack, rsp_err, busy, bus_active, scl_oe, sda_oe;
    logic [7:0] rsp_data;
    logic scl_in, sda_in;

    logic [1:0] mode = '0;
    logic [7:0] rd_byte = '0;
    logic slave_ack = 1'b0;
    logic stretch_arm = 1'b0;
    logic slave_pull;

    int checks = 0;
    int failures = 0;
    int ncyc = 0, acc = 0, k = 0, bitn = 0, stretch_left = 0, rsp_cnt = 0;
    logic pend = 1'b0, prev_scl = 1'b0;
    logic [8:0] seen = '0;
    logic [1:0] or_acc = '0;
    logic sda_hist[200];
    logic scl_hist[200];
    vec_t exp_q[$];
    vec_t e;
    vec_t tbl[14];

    i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_ack_out(cmd_ack_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .rsp_err(rsp_err), .busy(busy), .bus_active(bus_active),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    always_comb begin
        slave_pull = 1'b0;
        if (mode == 2'd2 && bitn >= 1 && bitn <= 8) slave_pull = ~rd_byte[8 - bitn];
        if (mode == 2'd1 && bitn == 9) slave_pull = slave_ack;
    end

    assign sda_in = ~sda_oe & ~slave_pull;
    assign scl_in = ~scl_oe & ~(stretch_left > 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (stretch_left > 0) stretch_left--;
        if (!rst_) begin
            if (cmd_valid && cmd_ready) begin
                acc = ncyc;
                bitn = 0;
                pend = 1'b0;
                seen = '0;
                or_acc = '0;
            end else begin
                k = ncyc - acc;
                if (k < 200) begin
                    sda_hist[k] = sda_oe;
                    scl_hist[k] = scl_oe;
                end
                if (k == 1) chk("busy_after_accept", {busy, cmd_ready}, 2'b10);
                or_acc = or_acc | {scl_oe, sda_oe};
                if (pend) begin
                    seen = {seen[7:0], sda_in};
                    pend = 1'b0;
                end
                if (prev_scl && !scl_oe) begin
                    bitn++;
                    pend = 1'b1;
                    if (bitn == 1 && stretch_arm) stretch_left = 20;
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", ncyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", ncyc - acc, e.lat);
                    chk("rsp_err", rsp_err, e.err);
                    chk("bus_active", bus_active, e.bus);
                    if (e.chk) begin
                        chk("rsp_data", rsp_data, e.edata);
                        chk("rsp_nack", rsp_nack, e.enack);
                    end
                    if ((e.op == 2'd1 || e.op == 2'd2) && !e.err) chk("scl_high_sda", seen, e.eseen);
                    if (e.chk_or) chk("line_activity", or_acc, e.eor);
                    if (e.chk_tim) begin
                        chk("start_sda_T8", sda_hist[8], 1'b0);
                        chk("start_sda_T9", sda_hist[9], 1'b1);
                        chk("start_scl_T16", scl_hist[16], 1'b0);
                        chk("start_scl_T17", scl_hist[17], 1'b1);
                    end
                end
                rsp_cnt++;
            end
        end
        prev_scl = scl_oe;
    end

    task automatic issue(input vec_t v);
        int n0;
        int w;
        #1;
        cmd_op = v.op;
        cmd_data = v.data;
        cmd_ack_out = v.ack;
        rd_byte = v.rd;
        slave_ack = v.sack;
        mode = v.op;
        stretch_arm = v.st;
        exp_q.push_back(v);
        n0 = rsp_cnt;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (v.poke) begin
            repeat (5) @(posedge clk);
            #1;
            cmd_op = 2'd3;
            cmd_valid = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
        w = 0;
        while (rsp_cnt == n0 && w < 400) begin
            @(posedge clk);
            w++;
        end
        if (rsp_cnt == n0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got no response after %0d cycles expected one", w);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        tbl[0]  = '{op: 2'd1, data: 8'h11, lat: 1, err: 1'b1, chk: 1'b1, chk_or: 1'b1, default: 0};
        tbl[1]  = '{op: 2'd3, lat: 1, err: 1'b1, chk_or: 1'b1, default: 0};
        tbl[2]  = '{op: 2'd2, lat: 1, err: 1'b1, chk_or: 1'b1, default: 0};
        tbl[3]  = '{op: 2'd0, lat: 17, bus: 1'b1, chk: 1'b1, chk_tim: 1'b1, default: 0};
        tbl[4]  = '{op: 2'd1, data: 8'hA5, sack: 1'b1, lat: 145, bus: 1'b1, chk: 1'b1, edata: 8'hA5,
                    eseen: {8'hA5, 1'b0}, default: 0};
        tbl[5]  = '{op: 2'd2, ack: 1'b1, rd: 8'h3C, lat: 145, bus: 1'b1, chk: 1'b1, edata: 8'h3C, enack: 1'b1,
                    eseen: {8'h3C, 1'b1}, chk_or: 1'b1, eor: 2'b10, default: 0};
        tbl[6]  = '{op: 2'd0, poke: 1'b1, lat: 17, bus: 1'b1, chk: 1'b1, edata: 8'h3C, enack: 1'b1, default: 0};
        tbl[7]  = '{op: 2'd1, data: 8'h5A, lat: 145, bus: 1'b1, chk: 1'b1, edata: 8'h5A, enack: 1'b1,
                    eseen: {8'h5A, 1'b1}, default: 0};
        tbl[8]  = '{op: 2'd2, rd: 8'hC3, lat: 145, bus: 1'b1, chk: 1'b1, edata: 8'hC3,
                    eseen: {8'hC3, 1'b0}, default: 0};
        tbl[9]  = '{op: 2'd3, lat: 17, chk: 1'b1, edata: 8'hC3, default: 0};
        tbl[10] = '{op: 2'd1, data: 8'hFF, lat: 1, err: 1'b1, chk: 1'b1, edata: 8'hC3, chk_or: 1'b1, default: 0};
        tbl[11] = '{op: 2'd0, lat: 17, bus: 1'b1, default: 0};
        tbl[12] = '{op: 2'd1, data: 8'h96, sack: 1'b1, st: 1'b1, lat: LS, bus: 1'b1, chk: 1'b1, edata: 8'h96,
                    eseen: {8'h96, 1'b0}, default: 0};
        tbl[13] = '{op: 2'd3, lat: 17, default: 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_nack, rsp_data}, 11'd0);
        chk("rst_lines", {bus_active, scl_oe, sda_oe}, 3'b000);
        rst_ = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 14; i++) issue(tbl[i]);

        issue(tbl[11]);
        #1;
        cmd_op = 2'd1;
        cmd_data = 8'h00;
        cmd_ack_out = 1'b0;
        mode = 2'd1;
        slave_ack = 1'b0;
        stretch_arm = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        w = 0;
        while (bitn < 4 && w < 400) begin
            @(posedge clk);
            w++;
        end
        #1;
        while (!scl_oe && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("bit4_lines_before_rst", {scl_oe, sda_oe}, 2'b11);
        #2;
        rst_ = 1'b1;
        #1;
        chk("rst_mid_lines", {scl_oe, sda_oe}, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        chk("rst_mid_ready", {cmd_ready, busy}, 2'b10);
        chk("rst_mid_bus", bus_active, 1'b0);
        chk("rst_mid_pending", exp_q.size(), 0);
        @(posedge clk);
        issue(tbl[3]);
        issue(tbl[13]);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
